// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch direction predictor.
//   bp_cnt_t    - 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST)
//   bp_state_t  - predictor FSM state (BP_INIT sweep, BP_RUN)
//   bp_sat_next - counter training step toward the resolved direction
package bp_pkg;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t BP_SNT = 2'b00;
    localparam bp_cnt_t BP_WNT = 2'b01;
    localparam bp_cnt_t BP_WT  = 2'b10;
    localparam bp_cnt_t BP_ST  = 2'b11;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    function automatic bp_cnt_t bp_sat_next(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t nxt;
        if (taken) begin
            nxt = (cnt == BP_ST) ? BP_ST : bp_cnt_t'(cnt + 2'd1);
        end else begin
            nxt = (cnt == BP_SNT) ? BP_SNT : bp_cnt_t'(cnt - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side prediction, EX-side training and statistics
// signals of the branch predictor.
//   master - pipeline side: drives pred_pc and upd_*, observes prediction/stats
//   slave  - predictor side
interface branch_predictor_if #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned XLEN    = 32
);
    localparam int unsigned IDX = $clog2(ENTRIES);

    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic [IDX-1:0]  pred_hist;
    logic            ready;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_pred;
    logic [IDX-1:0]  upd_hist;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_taken, upd_pred, upd_hist,
        input  pred_taken, pred_hist, ready, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_taken, upd_pred, upd_hist,
        output pred_taken, pred_hist, ready, stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/bp_table.sv
// bp_table: ENTRIES x 2-bit counter storage.
//   clk        - clock
//   rd_idx_i   - asynchronous read index (prediction path)
//   rd_cnt_o   - counter at rd_idx_i, pre-update value on a same-cycle write
//   wr_en_i    - write enable
//   wr_init_i  - 1: write weak-not-taken (init sweep); 0: train toward wr_taken_i
//   wr_idx_i   - write index
//   wr_taken_i - resolved direction for a training write
// Storage has no reset; the init sweep defines every entry.
module bp_table
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX     = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic [IDX-1:0] rd_idx_i,
    output bp_cnt_t        rd_cnt_o,
    input  logic           wr_en_i,
    input  logic           wr_init_i,
    input  logic [IDX-1:0] wr_idx_i,
    input  logic           wr_taken_i
);

    bp_cnt_t mem_q [ENTRIES];

    assign rd_cnt_o = mem_q[rd_idx_i];

    // Training is a read-modify-write local to the write port, so the
    // prediction read port stays independent of the update index.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_init_i ? BP_WNT : bp_sat_next(mem_q[wr_idx_i], wr_taken_i);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating counter direction predictor with
// saturating branch / mispredict statistics.
//   clk - clock, all state on posedge
//   rst - synchronous active-high reset; restarts the table init sweep
//   bp  - branch_predictor_if.slave: prediction (pred_*), training (upd_*),
//         ready flag and statistics
// Build option: define BP_GSHARE_EN to XOR a global history register into the
// index (gshare); otherwise indexing is bimodal and pred_hist is tied to 0.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned XLEN    = 32
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bp
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    bp_state_t      state_q, state_d;
    logic [IDX-1:0] init_ptr_q, init_ptr_d;
    logic [31:0]    stat_branches_q, stat_branches_d;
    logic [31:0]    stat_mispredicts_q, stat_mispredicts_d;

    logic           ready;
    logic           accept;
    logic           tbl_init;
    logic           tbl_we;
    logic [IDX-1:0] tbl_widx;
    logic [IDX-1:0] pred_idx;
    logic [IDX-1:0] upd_idx;
    bp_cnt_t        rd_cnt;

    logic           unused_pc;
    assign unused_pc = ^{bp.pred_pc[XLEN-1:IDX+2], bp.pred_pc[1:0],
                         bp.upd_pc[XLEN-1:IDX+2], bp.upd_pc[1:0]};

    assign ready    = (state_q == BP_RUN);
    assign accept   = bp.upd_valid && ready && !rst;
    assign tbl_init = (state_q == BP_INIT);
    assign tbl_we   = !rst && (tbl_init || accept);
    assign tbl_widx = tbl_init ? init_ptr_q : upd_idx;

`ifdef BP_GSHARE_EN
    logic [IDX-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (accept) begin
            ghr_d = {ghr_q[IDX-2:0], bp.upd_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Prediction hashes with the live history; training uses the snapshot
    // that travelled down the pipe with the branch.
    assign pred_idx     = bp.pred_pc[IDX+1:2] ^ ghr_q;
    assign upd_idx      = bp.upd_pc[IDX+1:2] ^ bp.upd_hist;
    assign bp.pred_hist = ghr_q;
`else
    logic unused_hist;
    assign unused_hist  = ^bp.upd_hist;

    assign pred_idx     = bp.pred_pc[IDX+1:2];
    assign upd_idx      = bp.upd_pc[IDX+1:2];
    assign bp.pred_hist = '0;
`endif

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            BP_INIT: begin
                init_ptr_d = init_ptr_q + IDX'(1);
                if (init_ptr_q == IDX'(ENTRIES - 1)) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                state_d = BP_RUN;
            end
            default: begin
                state_d = BP_INIT;
            end
        endcase
    end

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (accept) begin
            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + 32'd1;
            end
            if ((bp.upd_pred != bp.upd_taken) && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= BP_INIT;
            init_ptr_q         <= '0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            state_q            <= state_d;
            init_ptr_q         <= init_ptr_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDX     (IDX)
    ) u_table (
        .clk        (clk),
        .rd_idx_i   (pred_idx),
        .rd_cnt_o   (rd_cnt),
        .wr_en_i    (tbl_we),
        .wr_init_i  (tbl_init),
        .wr_idx_i   (tbl_widx),
        .wr_taken_i (bp.upd_taken)
    );

    assign bp.ready            = ready;
    assign bp.pred_taken       = ready && rd_cnt[1];
    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: self-checking bench for branch_predictor (ENTRIES=64).
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned XLEN    = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_predictor_if #(.ENTRIES(ENTRIES), .XLEN(XLEN)) bpi ();

    branch_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpi)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        pred;
        logic [31:0] chk_pc;
        logic        exp_taken;
    } vec_t;

    typedef struct {
        string       name;
        logic        exp_taken;
        logic [31:0] exp_br;
        logic [31:0] exp_mp;
        logic [5:0]  exp_hist;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_br    = '0;
    logic [31:0] m_mp    = '0;
    logic [5:0]  m_ghr   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic taken, input logic pred);
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
        if (pred != taken && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 32'd1;
`ifdef BP_GSHARE_EN
        m_ghr = {m_ghr[4:0], taken};
`endif
    endtask

    task automatic pop_check(input logic [31:0] chk_pc);
        exp_t e;
        bpi.pred_pc = chk_pc;
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, "_pred"},  {31'd0, bpi.pred_taken}, {31'd0, e.exp_taken});
            check({e.name, "_br"},    bpi.stat_branches, e.exp_br);
            check({e.name, "_mp"},    bpi.stat_mispredicts, e.exp_mp);
            check({e.name, "_hist"},  {26'd0, bpi.pred_hist}, {26'd0, e.exp_hist});
        end
    endtask

    task automatic push_exp(input string name, input logic exp_taken);
        exp_t e;
        e.name      = name;
        e.exp_taken = exp_taken;
        e.exp_br    = m_br;
        e.exp_mp    = m_mp;
        e.exp_hist  = m_ghr;
        sb.push_back(e);
    endtask

    task automatic do_update(input string name, input logic [31:0] pc, input logic taken,
                             input logic pred, input logic [5:0] hist,
                             input logic [31:0] chk_pc, input logic exp_taken);
        @(negedge clk);
        bpi.upd_pc    = pc;
        bpi.upd_taken = taken;
        bpi.upd_pred  = pred;
        bpi.upd_hist  = hist;
        bpi.upd_valid = 1'b1;
        model_update(taken, pred);
        push_exp(name, exp_taken);
        @(negedge clk);
        bpi.upd_valid = 1'b0;
        pop_check(chk_pc);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bpi.ready && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic reset_and_init(input int hold, input string tag);
        int cycles;
        @(negedge clk);
        rst = 1'b1;
        repeat (hold) @(negedge clk);
        #1;
        check({tag, "_rst_ready"}, {31'd0, bpi.ready}, 32'd0);
        check({tag, "_rst_br"},    bpi.stat_branches, 32'd0);
        check({tag, "_rst_mp"},    bpi.stat_mispredicts, 32'd0);
        check({tag, "_rst_hist"},  {26'd0, bpi.pred_hist}, 32'd0);
        m_br  = '0;
        m_mp  = '0;
        m_ghr = '0;
        // Updates offered throughout the sweep must all be dropped.
        bpi.upd_valid = 1'b1;
        bpi.upd_pc    = 32'h40;
        bpi.upd_taken = 1'b1;
        bpi.upd_pred  = 1'b0;
        bpi.upd_hist  = '0;
        rst = 1'b0;
        wait_ready(cycles);
        bpi.upd_valid = 1'b0;
        check({tag, "_init_cycles"}, cycles, 32'd64);
        bpi.pred_pc = 32'h100;
        #1;
        check({tag, "_pred_0x100"}, {31'd0, bpi.pred_taken}, 32'd0);
        bpi.pred_pc = 32'h40;
        #1;
        check({tag, "_pred_0x40"},  {31'd0, bpi.pred_taken}, 32'd0);
        check({tag, "_init_br"},    bpi.stat_branches, 32'd0);
        check({tag, "_init_mp"},    bpi.stat_mispredicts, 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        rst           = 1'b1;
        bpi.pred_pc   = '0;
        bpi.upd_valid = 1'b0;
        bpi.upd_pc    = '0;
        bpi.upd_taken = 1'b0;
        bpi.upd_pred  = 1'b0;
        bpi.upd_hist  = '0;

        // pc, taken, pred, chk_pc, exp_taken
        vecs[0]  = '{32'h40,  1'b1, 1'b0, 32'h40,  1'b1};  // e16 01->10
        vecs[1]  = '{32'h40,  1'b1, 1'b1, 32'h140, 1'b1};  // e16 ->11, alias
        vecs[2]  = '{32'h40,  1'b0, 1'b1, 32'h40,  1'b1};  // ->10
        vecs[3]  = '{32'h40,  1'b0, 1'b1, 32'h40,  1'b0};  // ->01
        vecs[4]  = '{32'h40,  1'b0, 1'b0, 32'h40,  1'b0};  // ->00
        vecs[5]  = '{32'h40,  1'b0, 1'b0, 32'h40,  1'b0};  // stays 00
        vecs[6]  = '{32'h40,  1'b1, 1'b0, 32'h40,  1'b0};  // ->01
        vecs[7]  = '{32'h40,  1'b1, 1'b0, 32'h40,  1'b1};  // ->10
        vecs[8]  = '{32'h80,  1'b0, 1'b1, 32'h80,  1'b0};  // e32 01->00
        vecs[9]  = '{32'h80,  1'b1, 1'b1, 32'h80,  1'b0};  // e32 ->01
        vecs[10] = '{32'h44,  1'b1, 1'b0, 32'h40,  1'b1};  // e17 ->10, e16 intact

        reset_and_init(2, "boot");

`ifdef BP_GSHARE_EN
        do_update("gs_t1", 32'h58, 1'b1, 1'b0, 6'd0, 32'h58, 1'b0);
        do_update("gs_t2", 32'h58, 1'b1, 1'b0, 6'd0, 32'h58, 1'b0);
        do_update("gs_n3", 32'h00, 1'b0, 1'b0, 6'd0, 32'h40, 1'b1);
        check("gs_hist_6", {26'd0, bpi.pred_hist}, 32'd6);
`else
        for (int i = 0; i < 11; i++) begin
            do_update($sformatf("vec%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].pred,
                      6'd0, vecs[i].chk_pc, vecs[i].exp_taken);
        end

        // Same-cycle read and write of entry 32: read sees the old counter.
        @(negedge clk);
        bpi.upd_pc    = 32'h80;
        bpi.upd_taken = 1'b1;
        bpi.upd_pred  = 1'b0;
        bpi.upd_valid = 1'b1;
        bpi.pred_pc   = 32'h80;
        #1;
        check("nobypass_pre", {31'd0, bpi.pred_taken}, 32'd0);
        model_update(1'b1, 1'b0);
        push_exp("nobypass_post", 1'b1);
        @(negedge clk);
        bpi.upd_valid = 1'b0;
        pop_check(32'h80);

        // Train entry 16 to strong-taken, then reset in RUN.
        do_update("train_st", 32'h40, 1'b1, 1'b1, 6'd0, 32'h40, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("runrst_ready_drop", {31'd0, bpi.ready}, 32'd0);
        reset_and_init(1, "rerun");

        do_update("after_rst", 32'h40, 1'b1, 1'b1, 6'd0, 32'h40, 1'b1);

        // Statistics saturation: next-state with both counters pinned at max.
        @(negedge clk);
        force dut.stat_branches_q    = 32'hFFFF_FFFF;
        force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
        bpi.upd_pc    = 32'h80;
        bpi.upd_taken = 1'b0;
        bpi.upd_pred  = 1'b1;
        bpi.upd_valid = 1'b1;
        #1;
        check("sat_br_next", dut.stat_branches_d,    32'hFFFF_FFFF);
        check("sat_mp_next", dut.stat_mispredicts_d, 32'hFFFF_FFFF);
        @(negedge clk);
        bpi.upd_valid = 1'b0;
        release dut.stat_branches_q;
        release dut.stat_mispredicts_q;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch direction predictor for the five-stage RISC-V pipeline. It gives IF a taken/not-taken guess for the current PC from a table of 2-bit saturating counters. The EX-stage branch comparator's resolved outcome trains the table, closing the loop from branch resolution back to fetch. It also keeps saturating branch and mispredict statistics counters.

## Interface
- `ENTRIES`, 64: number of counters; power of two, ≥ 4; `IDX = $clog2(ENTRIES)`.
- `XLEN`, 32: PC width.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `pred_pc` in XLEN: PC of the instruction in IF.
- `pred_taken` out 1: predicted direction for `pred_pc`; combinational from registered state.
- `pred_hist` out IDX: history snapshot used for this prediction; IF/ID/EX pipeline it to `upd_hist`.
- `ready` out 1: table initialised; predictions and updates are live.
- `upd_valid` in 1: EX resolved a conditional branch this cycle.
- `upd_pc` in XLEN: PC of the resolved branch.
- `upd_taken` in 1: resolved outcome from the branch comparator.
- `upd_pred` in 1: `pred_taken` originally issued for this branch, piped to EX.
- `upd_hist` in IDX: `pred_hist` originally issued for this branch.
- `stat_branches` out 32: count of accepted updates.
- `stat_mispredicts` out 32: count of accepted updates with `upd_pred != upd_taken`.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is the counter MSB.
- Index: `pc[IDX+1:2]`. With `BP_GSHARE_EN`, this value is XORed with the history. The prediction path uses the live GHR; the update path uses `upd_hist`.
- FSM states:
  - INIT: entered while `rst` is high. Each cycle with `rst` low writes 01 to entry `init_ptr` and increments `init_ptr`. After the write to entry `ENTRIES-1`, the FSM moves to RUN.
  - RUN: `ready` = 1. Stays in RUN until `rst`.
- During INIT:
  - `pred_taken` = 0.
  - `upd_valid` is ignored: no table write, no stats change, no GHR shift.
- An update is accepted when `upd_valid && ready`. On acceptance:
  - If `upd_taken`, the counter increments and saturates at 11. Otherwise it decrements and saturates at 00.
  - `stat_branches` increments.
  - `stat_mispredicts` increments when the prediction was wrong.
  - Both stats saturate at 0xFFFF_FFFF.
- Read and write in the same cycle to the same entry: the read returns the pre-update value. There is no bypass.
- Rising `rst` at any point returns to INIT. `init_ptr`, both stats and the GHR clear. Table contents are overwritten by the INIT sweep.

## Timing
- Reset values: `ready` = 0, `pred_taken` = 0, `pred_hist` = 0, `stat_branches` = 0, `stat_mispredicts` = 0.
- INIT duration is exactly `ENTRIES` cycles after `rst` falls. `ready` goes high on the cycle after the `ENTRIES`th post-reset posedge.
- Prediction latency: 0 cycles. `pred_taken` and `pred_hist` follow `pred_pc` combinationally.
- Update latency: 1 cycle. An accepted update at edge N is visible to `pred_taken` and the stats after edge N.
- There is no handshake back-pressure. Updates are never stalled, only dropped during INIT.

## Configuration
- `BP_GSHARE_EN` defined:
  - An IDX-bit global history register is compiled in.
  - Each accepted update shifts it left by one, inserting `upd_taken` at the LSB.
  - `pred_hist` = GHR.
  - Index = PC bits XOR history.
- `BP_GSHARE_EN` undefined:
  - No GHR is built.
  - `pred_hist` is tied to 0 and `upd_hist` is ignored.
  - Indexing is bimodal (PC bits only).
- The port list is identical in both builds.

## Structure
- Package `bp_pkg` holds:
  - Counter encoding constants `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`.
  - FSM state typedef `bp_state_t` with values `BP_INIT` and `BP_RUN`.
  - Function `bp_sat_next(cnt, taken)`.
- Sub-module `bp_table` is the `ENTRIES`×2 storage. It has one asynchronous read port and one synchronous write port. The write port is muxed between the INIT sweep and accepted updates.

## Test plan
All scenarios use `ENTRIES` = 64 and the default build unless noted.
1. Reset and INIT: hold `rst` high for 2 cycles, then release → `ready` = 0 for 64 cycles, then `ready` = 1. With `pred_pc` = 0x100 after that, `pred_taken` = 0. Both stats read 0.
2. Training and aliasing: apply two accepted updates at `upd_pc` = 0x40 with `upd_taken` = 1 → entry 16 steps 01→10→11. `pred_taken` = 1 for `pred_pc` = 0x40 and also for 0x140, which aliases to index 16.
3. Saturation: continue from scenario 2 with four not-taken updates at 0x40 → counter goes 11→10→01→00→00 and `pred_taken` = 0. Then two taken updates → 01→10, and `pred_taken` = 1.
4. Stats: apply one update with `upd_pred` = 1, `upd_taken` = 0, then one with `upd_pred` = 1, `upd_taken` = 1 → `stat_branches` = 2, `stat_mispredicts` = 1. Preload both stats to 0xFFFF_FFFF (force) and apply a mispredicted update → both stay 0xFFFF_FFFF.
5. Reset and INIT behaviour:
   - Assert `upd_valid` = 1 every cycle during INIT → no table writes and stats stay 0.
   - In RUN, after training 0x40 to 11, pulse `rst` → `ready` drops, and after INIT `pred_taken`(0x40) = 0.
6. `BP_GSHARE_EN` build: apply accepted updates T, T, N → `pred_hist` = 6'b000110. With `pred_pc` = 0x40, the prediction reads entry 16 ^ 6 = 22.
